// File: rtl/ram_access_pkg.sv
// Shared types and helpers for the RAM load/store front end.
package ram_access_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned LANE_W = 2;

    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_RSV} size_e;

    typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} state_e;

    // True when the request cannot be serviced: reserved size or unaligned lane.
    function automatic logic req_illegal(input size_e size, input logic [LANE_W-1:0] lane);
        logic bad;
        case (size)
            SZ_B:    bad = 1'b0;
            SZ_H:    bad = lane[0];
            SZ_W:    bad = |lane;
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/ram_lane_align.sv
// Byte-lane datapath: load extract/extend and sub-word store merge.
module ram_lane_align
    import ram_access_pkg::*;
(
    input  logic [DATA_W-1:0] word_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [LANE_W-1:0] lane_i,
    input  size_e             size_i,
    input  logic              uns_i,
    output logic [DATA_W-1:0] ld_data_c_o,
    output logic [DATA_W-1:0] st_data_c_o
);

    logic [7:0]  lane_byte;
    logic [15:0] lane_half;
    logic        sign_b;
    logic        sign_h;

    always_comb begin
        lane_byte = word_i[8*int'(lane_i) +: 8];
        lane_half = lane_i[1] ? word_i[31:16] : word_i[15:0];
        sign_b    = ~uns_i & lane_byte[7];
        sign_h    = ~uns_i & lane_half[15];

        ld_data_c_o = '0;
        case (size_i)
            SZ_B:    ld_data_c_o = {{24{sign_b}}, lane_byte};
            SZ_H:    ld_data_c_o = {{16{sign_h}}, lane_half};
            SZ_W:    ld_data_c_o = word_i;
            default: ld_data_c_o = '0;
        endcase
    end

    // Store merge: only the addressed lane(s) take new data.
    always_comb begin
        st_data_c_o = word_i;
        case (size_i)
            SZ_B:    st_data_c_o[8*int'(lane_i) +: 8] = wdata_i[7:0];
            SZ_H: begin
                if (lane_i[1]) st_data_c_o[31:16] = wdata_i[15:0];
                else           st_data_c_o[15:0]  = wdata_i[15:0];
            end
            SZ_W:    st_data_c_o = wdata_i;
            default: st_data_c_o = word_i;
        endcase
    end

endmodule

// File: rtl/ram_access_ctrl.sv
// Load/store front end for a single-port async-read word RAM; sub-word
// stores are done as a read-modify-write through the WRITE state.
module ram_access_ctrl
    import ram_access_pkg::*;
#(
    parameter int unsigned ADDRWIDTH = 6,
    parameter int unsigned DATAWIDTH = 32
) (
    input  logic                   iClk,
    input  logic                   iRst_n,
    input  logic                   iReqValid,
    output logic                   oReqReady,
    input  logic                   iReqWrite,
    input  logic [1:0]             iReqSize,
    input  logic                   iReqUnsigned,
    input  logic [ADDRWIDTH+1:0]   iReqAddr,
    input  logic [DATAWIDTH-1:0]   iReqWData,
    output logic                   oRspValid,
    input  logic                   iRspReady,
    output logic [DATAWIDTH-1:0]   oRspRData,
    output logic                   oRspErr,
    output logic                   oMemWR,
    output logic [ADDRWIDTH-1:0]   oMemAddress,
    output logic [DATAWIDTH-1:0]   oMemWriteData,
    input  logic [DATAWIDTH-1:0]   iMemReadData
);

    localparam int unsigned BADDR_W = ADDRWIDTH + 2;

    if (DATAWIDTH != 32) begin : g_width_check
        $error("ram_access_ctrl: DATAWIDTH must be 32");
    end

    state_e               state_q, state_d;
    logic                 write_q, write_d;
    size_e                size_q,  size_d;
    logic                 uns_q,   uns_d;
    logic [BADDR_W-1:0]   addr_q,  addr_d;
    logic [DATA_W-1:0]    wdata_q, wdata_d;
    logic [DATA_W-1:0]    merge_q, merge_d;
    logic [DATA_W-1:0]    rdata_q, rdata_d;
    logic                 err_q,   err_d;

    logic [DATA_W-1:0]    ld_data;
    logic [DATA_W-1:0]    st_data;
    size_e                req_size;

    assign req_size = size_e'(iReqSize);

    ram_lane_align u_align (
        .word_i      (iMemReadData),
        .wdata_i     (wdata_q),
        .lane_i      (addr_q[LANE_W-1:0]),
        .size_i      (size_q),
        .uns_i       (uns_q),
        .ld_data_c_o (ld_data),
        .st_data_c_o (st_data)
    );

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q <= IDLE;
            write_q <= 1'b0;
            size_q  <= SZ_B;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            merge_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            write_q <= write_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            merge_q <= merge_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Next-state and request/response register updates.
    always_comb begin
        state_d = state_q;
        write_d = write_q;
        size_d  = size_q;
        uns_d   = uns_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        merge_d = merge_q;
        rdata_d = rdata_q;
        err_d   = err_q;

        case (state_q)
            IDLE: begin
                if (iReqValid) begin
                    write_d = iReqWrite;
                    size_d  = req_size;
                    uns_d   = iReqUnsigned;
                    addr_d  = iReqAddr;
                    wdata_d = iReqWData;
                    rdata_d = '0;
                    err_d   = req_illegal(req_size, iReqAddr[LANE_W-1:0]);
                    state_d = err_d ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                if (write_q) begin
                    if (size_q == SZ_W) begin
                        state_d = RESP;
                    end else begin
                        merge_d = st_data;
                        state_d = WRITE;
                    end
                end else begin
                    rdata_d = ld_data;
                    state_d = RESP;
                end
            end
            WRITE: begin
                state_d = RESP;
            end
            RESP: begin
                if (iRspReady) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // RAM write port: a word store writes in ACCESS, sub-word stores in WRITE.
    always_comb begin
        oMemWR        = 1'b0;
        oMemWriteData = '0;
        if (state_q == ACCESS && write_q && size_q == SZ_W) begin
            oMemWR        = 1'b1;
            oMemWriteData = wdata_q;
        end else if (state_q == WRITE) begin
            oMemWR        = 1'b1;
            oMemWriteData = merge_q;
        end
    end

    assign oReqReady   = (state_q == IDLE);
    assign oRspValid   = (state_q == RESP);
    assign oRspRData   = rdata_q;
    assign oRspErr     = err_q;
    assign oMemAddress = addr_q[BADDR_W-1:LANE_W];

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Directed self-checking bench for ram_access_ctrl with an async-read RAM model.
module tb_ram_access_ctrl;

    localparam int unsigned AW = 6;

    logic          clk;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [1:0]    req_size;
    logic          req_uns;
    logic [AW+1:0] req_addr;
    logic [31:0]   req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;
    logic          mem_wr;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    logic [31:0]   mem [0:(1<<AW)-1];

    int n_vec = 0;
    int n_err = 0;

    ram_access_ctrl #(.ADDRWIDTH(AW), .DATAWIDTH(32)) dut (
        .iClk          (clk),
        .iRst_n        (rst_n),
        .iReqValid     (req_valid),
        .oReqReady     (req_ready),
        .iReqWrite     (req_write),
        .iReqSize      (req_size),
        .iReqUnsigned  (req_uns),
        .iReqAddr      (req_addr),
        .iReqWData     (req_wdata),
        .oRspValid     (rsp_valid),
        .iRspReady     (rsp_ready),
        .oRspRData     (rsp_rdata),
        .oRspErr       (rsp_err),
        .oMemWR        (mem_wr),
        .oMemAddress   (mem_addr),
        .oMemWriteData (mem_wdata),
        .iMemReadData  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) begin
        if (mem_wr) mem[mem_addr] <= mem_wdata;
    end

    // Issue one request and follow it to its response; returns cycles from the
    // accept edge to rsp_valid, number of oMemWR cycles, and the response.
    task automatic issue(input logic w, input logic [1:0] sz, input logic uns,
                         input logic [AW+1:0] a, input logic [31:0] wd,
                         output int lat, output int wrc, output logic [AW-1:0] maddr,
                         output logic [31:0] rd, output logic er);
        int guard;
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(posedge clk); #1; guard++;
        end
        req_valid = 1'b1; req_write = w; req_size = sz; req_uns = uns;
        req_addr = a; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
        maddr = mem_addr;
        lat = 1; wrc = 0;
        while (!rsp_valid && lat < 10) begin
            if (mem_wr) wrc++;
            @(posedge clk); #1; lat++;
        end
        if (mem_wr) wrc++;
        rd = rsp_rdata; er = rsp_err;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_vec++; if (req_ready !== 1'b1)  begin n_err++; $display("FAIL reset_ready got %b want 1", req_ready); end
        n_vec++; if (rsp_valid !== 1'b0)  begin n_err++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
        n_vec++; if (rsp_rdata !== 32'h0) begin n_err++; $display("FAIL reset_rdata got %h want 0", rsp_rdata); end
        n_vec++; if (rsp_err !== 1'b0)    begin n_err++; $display("FAIL reset_err got %b want 0", rsp_err); end
        n_vec++; if (mem_wr !== 1'b0)     begin n_err++; $display("FAIL reset_mem_wr got %b want 0", mem_wr); end
        n_vec++; if (mem_addr !== 6'h0)   begin n_err++; $display("FAIL reset_mem_addr got %h want 0", mem_addr); end
        n_vec++; if (mem_wdata !== 32'h0) begin n_err++; $display("FAIL reset_mem_wdata got %h want 0", mem_wdata); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_vec++; if (req_ready !== 1'b1)  begin n_err++; $display("FAIL post_reset_ready got %b want 1", req_ready); end
    endtask

    task automatic test_word_access();
        int lat, wrc; logic [AW-1:0] ma; logic [31:0] rd; logic er;
        issue(1'b1, 2'b10, 1'b0, 8'h40, 32'hDEADBEEF, lat, wrc, ma, rd, er);
        n_vec++; if (ma !== 6'h10)          begin n_err++; $display("FAIL wst_addr got %h want 10", ma); end
        n_vec++; if (wrc !== 1)             begin n_err++; $display("FAIL wst_wr_cycles got %0d want 1", wrc); end
        n_vec++; if (lat !== 2)             begin n_err++; $display("FAIL wst_latency got %0d want 2", lat); end
        n_vec++; if (rd !== 32'h0 || er !== 1'b0) begin n_err++; $display("FAIL wst_rsp got %h/%b want 0/0", rd, er); end
        n_vec++; if (mem[16] !== 32'hDEADBEEF) begin n_err++; $display("FAIL wst_ram got %h want deadbeef", mem[16]); end
        issue(1'b0, 2'b10, 1'b0, 8'h40, 32'h0, lat, wrc, ma, rd, er);
        n_vec++; if (rd !== 32'hDEADBEEF)   begin n_err++; $display("FAIL wld_data got %h want deadbeef", rd); end
        n_vec++; if (er !== 1'b0)           begin n_err++; $display("FAIL wld_err got %b want 0", er); end
        n_vec++; if (lat !== 2)             begin n_err++; $display("FAIL wld_latency got %0d want 2", lat); end
        n_vec++; if (wrc !== 0)             begin n_err++; $display("FAIL wld_wr_cycles got %0d want 0", wrc); end
    endtask

    task automatic test_subword_loads();
        logic [1:0]    sz [4] = '{2'b00, 2'b00, 2'b01, 2'b01};
        logic          un [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [AW+1:0] ad [4] = '{8'h43, 8'h43, 8'h42, 8'h40};
        logic [31:0]   ex [4] = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFDEAD, 32'h0000BEEF};
        int lat, wrc; logic [AW-1:0] ma; logic [31:0] rd; logic er;
        for (int i = 0; i < 4; i++) begin
            issue(1'b0, sz[i], un[i], ad[i], 32'h0, lat, wrc, ma, rd, er);
            n_vec++; if (rd !== ex[i] || er !== 1'b0 || lat !== 2) begin
                n_err++; $display("FAIL subld_%0d got %h err=%b lat=%0d want %h err=0 lat=2", i, rd, er, lat, ex[i]);
            end
        end
    endtask

    task automatic test_byte_store();
        int lat, wrc; logic [AW-1:0] ma; logic [31:0] rd; logic er;
        issue(1'b1, 2'b00, 1'b0, 8'h41, 32'h00000055, lat, wrc, ma, rd, er);
        n_vec++; if (wrc !== 1)    begin n_err++; $display("FAIL bst_wr_cycles got %0d want 1", wrc); end
        n_vec++; if (lat !== 3)    begin n_err++; $display("FAIL bst_latency got %0d want 3", lat); end
        n_vec++; if (er !== 1'b0)  begin n_err++; $display("FAIL bst_err got %b want 0", er); end
        issue(1'b0, 2'b10, 1'b0, 8'h40, 32'h0, lat, wrc, ma, rd, er);
        n_vec++; if (rd !== 32'hDEAD55EF) begin n_err++; $display("FAIL bst_readback got %h want dead55ef", rd); end
    endtask

    task automatic test_errors();
        logic [1:0]    sz [3] = '{2'b01, 2'b10, 2'b11};
        logic [AW+1:0] ad [3] = '{8'h41, 8'h42, 8'h40};
        int lat, wrc; logic [AW-1:0] ma; logic [31:0] rd; logic er;
        for (int i = 0; i < 3; i++) begin
            issue(1'b1, sz[i], 1'b0, ad[i], 32'h12345678, lat, wrc, ma, rd, er);
            n_vec++; if (er !== 1'b1 || rd !== 32'h0) begin
                n_err++; $display("FAIL err_%0d_rsp got err=%b rdata=%h want err=1 rdata=0", i, er, rd);
            end
            n_vec++; if (lat !== 1 || wrc !== 0) begin
                n_err++; $display("FAIL err_%0d_timing got lat=%0d wr=%0d want lat=1 wr=0", i, lat, wrc);
            end
            n_vec++; if (mem[16] !== 32'hDEAD55EF) begin
                n_err++; $display("FAIL err_%0d_ram got %h want dead55ef", i, mem[16]);
            end
        end
    endtask

    task automatic test_backpressure();
        int guard;
        logic ok;
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_uns = 1'b0;
        req_addr = 8'h40; req_wdata = 32'h0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        guard = 0;
        while (!rsp_valid && guard < 10) begin
            @(posedge clk); #1; guard++;
        end
        ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEAD55EF || req_ready !== 1'b0) ok = 1'b0;
            @(posedge clk); #1;
        end
        n_vec++; if (ok !== 1'b1) begin
            n_err++; $display("FAIL bp_hold got valid=%b rdata=%h ready=%b want 1/dead55ef/0", rsp_valid, rsp_rdata, req_ready);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        n_vec++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            n_err++; $display("FAIL bp_release got ready=%b valid=%b want 1/0", req_ready, rsp_valid);
        end
    endtask

    task automatic test_reset_mid_rmw();
        int lat, wrc; logic [AW-1:0] ma; logic [31:0] rd; logic er;
        logic seen_rsp;
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_uns = 1'b0;
        req_addr = 8'h42; req_wdata = 32'h000000AA;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        n_vec++; if (mem_wr !== 1'b1) begin n_err++; $display("FAIL rst_mid_write_state got wr=%b want 1", mem_wr); end
        #1 rst_n = 1'b0;
        #1;
        n_vec++; if (mem_wr !== 1'b0) begin n_err++; $display("FAIL rst_mid_wr_drop got %b want 0", mem_wr); end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen_rsp = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (rsp_valid) seen_rsp = 1'b1;
        end
        n_vec++; if (seen_rsp !== 1'b0 || req_ready !== 1'b1) begin
            n_err++; $display("FAIL rst_mid_idle got rsp_seen=%b ready=%b want 0/1", seen_rsp, req_ready);
        end
        issue(1'b0, 2'b10, 1'b0, 8'h40, 32'h0, lat, wrc, ma, rd, er);
        n_vec++; if (rd !== 32'hDEAD55EF) begin n_err++; $display("FAIL rst_mid_ram got %h want dead55ef", rd); end
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = 32'h0;
        req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_uns = 1'b0;
        req_addr = '0; req_wdata = 32'h0; rsp_ready = 1'b0; rst_n = 1'b1;
        #3;
        test_reset();
        test_word_access();
        test_subword_loads();
        test_byte_store();
        test_errors();
        test_backpressure();
        test_reset_mid_rmw();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
